// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM generator.
package pwm_pkg;

    localparam int PWM_DEF_CTRVAL = 256;
    localparam int PWM_DEF_CTRLEN = $clog2(PWM_DEF_CTRVAL);

    typedef enum logic {
        PWM_LEFT   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Count width at the default range; modules redefine it from their own CTRLEN.
    typedef logic [PWM_DEF_CTRLEN-1:0] pwm_count_t;

    // Select width for n channels, never narrower than one bit.
    function automatic int pwm_sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_period_ctr.sv
// Shared period counter: left/center counting, direction flag and boundary detect.
module pwm_period_ctr
    import pwm_pkg::*;
#(
    parameter int CTRLEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [CTRLEN-1:0] period,
    input  pwm_mode_e         mode,
    output logic [CTRLEN-1:0] counter,
    output logic              boundary
);

    typedef logic [CTRLEN-1:0] count_t;

    count_t   counter_q, counter_d;
    pwm_dir_e dir_q, dir_d;

    always_comb begin
        counter_d = counter_q;
        dir_d     = dir_q;
        boundary  = 1'b0;
        if (tick) begin
            if (period == '0) begin
                boundary  = 1'b1;
                counter_d = '0;
                dir_d     = DIR_UP;
            end else if (mode == PWM_LEFT) begin
                if (counter_q == period) begin
                    boundary  = 1'b1;
                    counter_d = '0;
                    dir_d     = DIR_UP;
                end else begin
                    counter_d = counter_q + count_t'(1);
                end
            end else if (dir_q == DIR_UP) begin
                // With P==1 the turn-around lands directly on 0, so it is the boundary.
                if (counter_q == period && period == count_t'(1)) begin
                    boundary  = 1'b1;
                    counter_d = '0;
                    dir_d     = DIR_UP;
                end else if (counter_q == period) begin
                    counter_d = period - count_t'(1);
                    dir_d     = DIR_DOWN;
                end else begin
                    counter_d = counter_q + count_t'(1);
                end
            end else begin
                if (counter_q <= count_t'(1)) begin
                    boundary  = 1'b1;
                    counter_d = '0;
                    dir_d     = DIR_UP;
                end else begin
                    counter_d = counter_q - count_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_q <= '0;
            dir_q     <= DIR_UP;
        end else begin
            counter_q <= counter_d;
            dir_q     <= dir_d;
        end
    end

    assign counter = counter_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, double-buffered duty/period/mode/enable
// banks that commit together on each period boundary, and one compare per channel.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CTRVAL     = PWM_DEF_CTRVAL,
    parameter int CTRLEN     = $clog2(CTRVAL),
    parameter int CHLEN      = pwm_sel_width(NCH),
    parameter int DEF_PERIOD = CTRVAL - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              duty_wr,
    input  logic [CHLEN-1:0]  duty_ch,
    input  logic [CTRLEN-1:0] duty_val,
    input  logic              period_wr,
    input  logic [CTRLEN-1:0] period_val,
    input  logic              center_mode,
    input  logic [NCH-1:0]    ch_en,
    output logic [CTRLEN-1:0] counter,
    output logic [NCH-1:0]    pwm_out,
    output logic              sync
);

    typedef logic [CTRLEN-1:0] count_t;

    logic      boundary;
    count_t    period_sh_q, period_sh_d;
    count_t    period_act_q, period_act_d;
    pwm_mode_e mode_act_q, mode_act_d;
    logic [NCH-1:0] ch_en_act_q, ch_en_act_d;
    logic      sync_q, sync_d;

    pwm_period_ctr #(
        .CTRLEN (CTRLEN)
    ) u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (enable),
        .period   (period_act_q),
        .mode     (mode_act_q),
        .counter  (counter),
        .boundary (boundary)
    );

    // The shadow's next value feeds the commit so a same-cycle write is included.
    always_comb begin
        period_sh_d  = period_wr ? period_val : period_sh_q;
        period_act_d = boundary ? period_sh_d : period_act_q;
        mode_act_d   = mode_act_q;
        if (boundary) begin
            mode_act_d = center_mode ? PWM_CENTER : PWM_LEFT;
        end
        ch_en_act_d  = boundary ? ch_en : ch_en_act_q;
        sync_d       = boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_sh_q  <= count_t'(DEF_PERIOD);
            period_act_q <= count_t'(DEF_PERIOD);
            mode_act_q   <= PWM_LEFT;
            ch_en_act_q  <= '0;
            sync_q       <= 1'b0;
        end else begin
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            mode_act_q   <= mode_act_d;
            ch_en_act_q  <= ch_en_act_d;
            sync_q       <= sync_d;
        end
    end

    assign sync = sync_q;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            count_t duty_sh_q, duty_sh_d;
            count_t duty_act_q, duty_act_d;

            // Out-of-range channel indices never match any gi, so they are dropped.
            always_comb begin
                duty_sh_d = duty_sh_q;
                if (duty_wr && duty_ch == CHLEN'(gi)) begin
                    duty_sh_d = duty_val;
                end
                duty_act_d = boundary ? duty_sh_d : duty_act_q;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    duty_sh_q  <= '0;
                    duty_act_q <= '0;
                end else begin
                    duty_sh_q  <= duty_sh_d;
                    duty_act_q <= duty_act_d;
                end
            end

            assign pwm_out[gi] = ch_en_act_q[gi] && (counter < duty_act_q);
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with a queue scoreboard checked by an independent monitor.
module tb_pwm_multi;

    localparam int NCH    = 3;
    localparam int CTRVAL = 256;
    localparam int CTRLEN = 8;
    localparam int CHLEN  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              duty_wr = 1'b0;
    logic [CHLEN-1:0]  duty_ch = '0;
    logic [CTRLEN-1:0] duty_val = '0;
    logic              period_wr = 1'b0;
    logic [CTRLEN-1:0] period_val = '0;
    logic              center_mode = 1'b0;
    logic [NCH-1:0]    ch_en = '0;
    logic [CTRLEN-1:0] counter;
    logic [NCH-1:0]    pwm_out;
    logic              sync;

    pwm_multi #(
        .NCH    (NCH),
        .CTRVAL (CTRVAL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .duty_wr     (duty_wr),
        .duty_ch     (duty_ch),
        .duty_val    (duty_val),
        .period_wr   (period_wr),
        .period_val  (period_val),
        .center_mode (center_mode),
        .ch_en       (ch_en),
        .counter     (counter),
        .pwm_out     (pwm_out),
        .sync        (sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                ph;
        int                idx;
        logic [CTRLEN-1:0] c;
        logic [NCH-1:0]    p;
        logic              s;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    function automatic string ph_name(input int ph);
        case (ph)
            0: return "reset";
            1: return "left_default";
            2: return "left_duty64";
            3: return "center_p9";
            4: return "duty_edges";
            5: return "bnd_write_enable";
            6: return "mid_reset";
            default: return "other";
        endcase
    endfunction

    // Apply the already-driven inputs for one edge and queue the expected post-edge outputs.
    task automatic cyc(input int ph, input int ec, input logic [NCH-1:0] ep, input logic es);
        exp_t e;
        @(posedge clk);
        e.ph  = ph;
        e.idx = step_no;
        e.c   = CTRLEN'(ec);
        e.p   = ep;
        e.s   = es;
        sb_q.push_back(e);
        step_no++;
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (counter !== e.c || pwm_out !== e.p || sync !== e.s) begin
                    failures++;
                    $display("FAIL %s step %0d: got counter=%0d pwm=%b sync=%b, expected counter=%0d pwm=%b sync=%b",
                             ph_name(e.ph), e.idx, counter, pwm_out, sync, e.c, e.p, e.s);
                end else begin
                    $display("ok   %s step %0d counter=%0d pwm=%b sync=%b",
                             ph_name(e.ph), e.idx, counter, pwm_out, sync);
                end
            end
        end
    end

    initial begin : stim
        int c;
        int m;
        // Reset state
        cyc(0, 0, 3'b000, 1'b0);
        cyc(0, 0, 3'b000, 1'b0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Defaults: P=255 left, all channels disabled
        for (int k = 1; k <= 512; k++) cyc(1, k % 256, 3'b000, (k % 256) == 0);

        // Duty 64 on ch0: nothing changes until the wrap
        ch_en    = 3'b001;
        duty_wr  = 1'b1;
        duty_ch  = 2'd0;
        duty_val = 8'd64;
        for (int k = 1; k <= 255; k++) begin
            cyc(2, k, 3'b000, 1'b0);
            duty_wr = 1'b0;
        end
        cyc(2, 0, 3'b001, 1'b1);
        for (int k = 1; k <= 255; k++) cyc(2, k, (k < 64) ? 3'b001 : 3'b000, 1'b0);

        // Writes landing in the boundary cycle: center, P=9, ch1 duty 3
        period_wr   = 1'b1;
        period_val  = 8'd9;
        center_mode = 1'b1;
        duty_wr     = 1'b1;
        duty_ch     = 2'd1;
        duty_val    = 8'd3;
        ch_en       = 3'b011;
        cyc(3, 0, 3'b011, 1'b1);
        period_wr = 1'b0;
        duty_wr   = 1'b0;
        for (int t = 1; t <= 36; t++) begin
            m = t % 18;
            c = (m <= 9) ? m : 18 - m;
            cyc(3, c, {1'b0, c < 3, 1'b1}, m == 0);
        end

        // Duty edge values staged during a center period, then P=9 left
        for (int t = 1; t <= 18; t++) begin
            duty_wr = 1'b1;
            case (t)
                1: begin center_mode = 1'b0; ch_en = 3'b111; duty_ch = 2'd0; duty_val = 8'd0; end
                2: begin duty_ch = 2'd1; duty_val = 8'd10; end
                3: begin duty_ch = 2'd2; duty_val = 8'd255; end
                4: begin duty_ch = 2'd3; duty_val = 8'd5; end
                default: duty_wr = 1'b0;
            endcase
            c = (t <= 9) ? t : 18 - t;
            if (t == 18) cyc(4, 0, 3'b110, 1'b1);
            else         cyc(4, c, {1'b0, c < 3, 1'b1}, 1'b0);
        end
        duty_wr = 1'b0;
        for (int s = 1; s <= 20; s++) cyc(4, s % 10, 3'b110, (s % 10) == 0);

        // Write ch2=5 exactly in the boundary cycle, then freeze/resume with enable
        for (int s = 1; s <= 9; s++) cyc(5, s, 3'b110, 1'b0);
        duty_wr  = 1'b1;
        duty_ch  = 2'd2;
        duty_val = 8'd5;
        cyc(5, 0, 3'b110, 1'b1);
        duty_wr = 1'b0;
        for (int s = 1; s <= 3; s++) cyc(5, s, 3'b110, 1'b0);
        enable = 1'b0;
        repeat (4) cyc(5, 3, 3'b110, 1'b0);
        enable = 1'b1;
        for (int s = 4; s <= 9; s++) cyc(5, s, {s < 5, 2'b10}, 1'b0);
        enable = 1'b0;
        repeat (2) cyc(5, 9, 3'b010, 1'b0);
        enable = 1'b1;
        cyc(5, 0, 3'b110, 1'b1);

        // Pending shadow writes are discarded by a mid-period reset
        for (int s = 1; s <= 3; s++) begin
            if (s == 3) begin
                duty_wr  = 1'b1;
                duty_ch  = 2'd1;
                duty_val = 8'd100;
            end
            cyc(6, s, {s < 5, 2'b10}, 1'b0);
        end
        rst_n      = 1'b0;
        duty_ch    = 2'd0;
        duty_val   = 8'd200;
        period_wr  = 1'b1;
        period_val = 8'd50;
        cyc(6, 0, 3'b000, 1'b0);
        rst_n     = 1'b1;
        duty_wr   = 1'b0;
        period_wr = 1'b0;
        for (int k = 1; k <= 260; k++) cyc(6, k % 256, 3'b000, (k % 256) == 0);

        @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel, parametrised successor to the single-channel PWM generator.
- One shared period counter drives NCH compare channels.
- Features: programmable period, left-aligned or center-aligned counting, per-channel enable, and double-buffered (shadow) duty/period/mode registers that commit only at a period boundary.
- Sits between the drum-machine control/sequencer logic (register writes) and the audio/LED output pins; emits a period-sync pulse for downstream sample timing.

Parameters:
- NCH, 4, number of PWM channels.
- CTRVAL, 256, maximum counter range; period register max = CTRVAL-1.
- CTRLEN, $clog2(CTRVAL), counter/duty/period width.
- CHLEN, $clog2(NCH) (min 1), channel-select width.
- DEF_PERIOD, CTRVAL-1, reset value of active and shadow period.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  count tick; counter advances only when high.
- duty_wr  in  1  write strobe for duty shadow.
- duty_ch  in  CHLEN  channel index for duty_wr.
- duty_val  in  CTRLEN  duty value written to shadow.
- period_wr  in  1  write strobe for period shadow.
- period_val  in  CTRLEN  period value.
- center_mode  in  1  mode request (0 left, 1 center); sampled into shadow every cycle.
- ch_en  in  NCH  per-channel enable request; sampled into shadow every cycle.
- counter  out  CTRLEN  current counter value.
- pwm_out  out  NCH  PWM outputs.
- sync  out  1  one-cycle pulse on period boundary.

Behaviour:
- Reset (rst_n low at clk edge):
  - counter=0, dir=up.
  - All duty active/shadow = 0; period active/shadow = DEF_PERIOD.
  - Mode active = left; ch_en active = 0.
  - pwm_out = 0, sync = 0.
  - Reset mid-period aborts the period immediately; no commit.
- Let P = active period, tick = enable.
- Left mode:
  - On tick: if counter==P, counter<=0 (boundary); else counter+1.
  - Period = P+1 ticks.
- Center mode:
  - dir=up, tick: if counter==P, dir<=down and counter<=P-1; else counter+1.
  - dir=down, tick: if counter==1, counter<=0, dir<=up (boundary); else counter-1.
  - Period = 2P ticks.
- P==0 in either mode: counter stays 0; every tick is a boundary.
- enable low: counter, dir and all active registers hold; no boundary; pwm_out holds.
- pwm_out[i] = ch_en_act[i] && (counter < duty_act[i]).
  - Combinational from registered state; no added latency.
  - duty 0 → constant low. duty > P → constant high.
  - Center mode gives a symmetric pulse of width 2*duty-1 ticks (duty ≤ P).
- Shadow writes:
  - duty_wr writes duty_shadow[duty_ch]; duty_ch ≥ NCH is ignored.
  - period_wr writes period_shadow.
  - Writes never affect outputs before the next boundary.
- Boundary commit:
  - On the boundary edge: duty_act<=duty_shadow, period_act<=period_shadow, mode_act<=center_mode, ch_en_act<=ch_en, all simultaneously.
  - A write in the same cycle as a boundary is included in the commit (write-through).
  - The counter restarts at 0, dir=up, regardless of mode change.
- sync: registered; high for exactly the one clk following each boundary edge.
- Widths: all compares unsigned, CTRLEN bits; no arithmetic overflow (counter never exceeds P ≤ CTRVAL-1).

Decomposition:
- Package pwm_pkg:
  - typedef pwm_mode_e {PWM_LEFT, PWM_CENTER}.
  - typedef for the CTRLEN-wide count, parameterised via the module.
  - Localparam default CTRVAL.
- Sub-module pwm_period_ctr: counter, direction flag, boundary detect, P==0 handling.
- Top holds the shadow/active banks and NCH compare instances (generate loop).

Test Plan:
- Reset then enable=1, defaults (P=255, left, ch_en=0) → counter 0..255 wrap; sync pulses every 256 clks; pwm_out=0.
- ch_en=4'b0001, duty_wr ch0=64, left mode → after next boundary, pwm_out[0] high for counter 0..63 (64 clks), low 192; unchanged before the boundary.
- period_wr 9, center_mode=1, duty ch1=3, ch_en[1]=1 → counter 0..9..1,0; period 18 ticks; pwm_out[1] high at counter 0,1,2 up and 2,1 down (5 ticks).
- Duty edges, P=9 left: duty 0 → always low; duty 10 and 255 → always high; duty_ch=NCH write → no channel changes.
- Write duty ch2=5 in the exact boundary cycle → committed that boundary; enable toggled low mid-period → counter and pwm_out freeze, resume without skipping.
- rst_n low mid-period with pending shadow writes → next cycle all outputs 0, counter 0, period 255, pending writes lost.
